// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with 16-byte lines.
// A miss fetches the whole block from instruction memory, fills the line and replays the lookup.
module instruction_cache #(
  parameter int NUM_SETS   = 8,
  parameter int INDEX_BITS = 3
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         READ,
  input  logic [31:0]  ADDRESS,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_SETS-1:0] valid_reg;
  logic [TAG_BITS-1:0] tag_array  [NUM_SETS];
  logic [127:0]        data_array [NUM_SETS];

  logic [27:0]  fill_addr_reg;
  logic [127:0] fill_buf_reg;
  logic         first_cycle_reg;

  logic [1:0]            word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [127:0]          line_data;
  logic [31:0]           line_words [4];
  logic                  hit;
  logic                  miss;
  logic                  fill_done;
  logic                  unused_address_bits;

  assign word_sel            = ADDRESS[3:2];
  assign index               = ADDRESS[INDEX_BITS+3:4];
  assign tag                 = ADDRESS[31:INDEX_BITS+4];
  assign fill_idx            = fill_addr_reg[INDEX_BITS-1:0];
  assign fill_tag            = fill_addr_reg[27:INDEX_BITS];
  assign unused_address_bits = ^ADDRESS[1:0];

  assign line_data = data_array[index];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign line_words[gi] = line_data[32*gi +: 32];
    end
  endgenerate

  assign READDATA = line_words[word_sel];

  // Lookups are only meaningful in IDLE; during a fill the line store is in flux.
  assign hit  = READ && (state_reg == ST_IDLE) && valid_reg[index] && (tag_array[index] == tag);
  assign miss = READ && (state_reg == ST_IDLE) && !hit;

  // The first MEM_READ cycle is ignored so memory always sees the request before completing.
  assign fill_done = (state_reg == ST_MEM_READ) && !first_cycle_reg && !MEM_BUSYWAIT;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg       <= ST_IDLE;
      valid_reg       <= '0;
      fill_addr_reg   <= '0;
      fill_buf_reg    <= '0;
      first_cycle_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (miss) begin
        fill_addr_reg   <= ADDRESS[31:4];
        first_cycle_reg <= 1'b1;
      end
      if (state_reg == ST_MEM_READ) begin
        first_cycle_reg <= 1'b0;
        if (fill_done) begin
          fill_buf_reg <= MEM_READDATA;
        end
      end
      if (state_reg == ST_UPDATE) begin
        valid_reg[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET && (state_reg == ST_UPDATE)) begin
      tag_array[fill_idx]  <= fill_tag;
      data_array[fill_idx] <= fill_buf_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (miss) state_next = ST_MEM_READ;
      ST_MEM_READ: if (fill_done) state_next = ST_UPDATE;
      ST_UPDATE:   state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    BUSYWAIT    = READ && !hit;
    if (state_reg != ST_IDLE) begin
      BUSYWAIT = 1'b1;
    end
    if (state_reg == ST_MEM_READ) begin
      MEM_READ    = 1'b1;
      MEM_ADDRESS = fill_addr_reg;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: cold/conflict misses, hits, reset mid-fill,
// address stability during a fill and a full eight-set sweep against a small memory model.
module tb_instruction_cache;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         READ;
  logic [31:0]  ADDRESS;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int total = 0;
  int bad   = 0;
  int mem_lat = 5;
  int mem_cnt = 0;

  instruction_cache dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .READ         (READ),
    .ADDRESS      (ADDRESS),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLOCK = ~CLOCK;

  // Memory stays busy for mem_lat cycles of MEM_READ, then presents the block.
  function automatic logic [31:0] model_word(input logic [27:0] blk, input logic [1:0] w);
    logic [31:0] r;
    if (blk == 28'd0) begin
      case (w)
        2'd0:    r = 32'h8F108093;
        2'd1:    r = 32'h00500113;
        2'd2:    r = 32'h00000213;
        default: r = 32'h0000F613;
      endcase
    end else begin
      r = {blk[15:0] ^ 16'h5A5A, 8'hC0, 6'h00, w};
    end
    return r;
  endfunction

  function automatic logic [127:0] model_block(input logic [27:0] blk);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[32*w +: 32] = model_word(blk, w[1:0]);
    return b;
  endfunction

  always_ff @(posedge CLOCK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_lat);
  always_comb MEM_READDATA = model_block(MEM_ADDRESS);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_mr_cycles(input int lat);
    return (lat == 0) ? 2 : lat + 1;
  endfunction

  // One fetch: drive, ride out the stall, then check latency, memory traffic and data.
  task automatic fetch(input string tag, input logic [31:0] addr, input bit is_miss, input bit toggle);
    int stalls;
    int mr;
    logic [27:0] ma_obs;
    stalls = 0;
    mr     = 0;
    ma_obs = addr[31:4];
    @(posedge CLOCK); #1;
    READ    = 1'b1;
    ADDRESS = addr;
    @(negedge CLOCK);
    while (BUSYWAIT && stalls < 200) begin
      stalls++;
      if (MEM_READ) begin
        mr++;
        if (MEM_ADDRESS !== addr[31:4]) ma_obs = MEM_ADDRESS;
        if (toggle) ADDRESS = addr ^ 32'h0000_0FF0;
      end else begin
        ADDRESS = addr;
      end
      @(negedge CLOCK);
    end
    check({tag, "_stall"}, stalls, is_miss ? exp_mr_cycles(mem_lat) + 2 : 0);
    check({tag, "_mrcyc"}, mr, is_miss ? exp_mr_cycles(mem_lat) : 0);
    if (is_miss) check({tag, "_maddr"}, ma_obs, addr[31:4]);
    check({tag, "_data"}, READDATA, model_word(addr[31:4], addr[3:2]));
    $display("fetch %s addr=%h data=%h stalls=%0d memcyc=%0d", tag, addr, READDATA, stalls, mr);
  endtask

  task automatic do_reset();
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    READ  = 1'b0;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idle_bad;
    RESET   = 1'b1;
    READ    = 1'b0;
    ADDRESS = 32'h0;
    @(posedge CLOCK); @(posedge CLOCK); #1;

    // Reset state
    @(negedge CLOCK);
    check("rst_mr", MEM_READ, 1'b0);
    check("rst_ma", MEM_ADDRESS, 28'h0);
    check("rst_busy_r0", BUSYWAIT, 1'b0);
    READ = 1'b1;
    @(negedge CLOCK);
    check("rst_busy_r1", BUSYWAIT, 1'b1);
    $display("reset: busy=%b mem_read=%b", BUSYWAIT, MEM_READ);

    // 1. Cold miss at 0x0, memory busy for 5 cycles
    mem_lat = 5;
    @(posedge CLOCK); #1;
    RESET   = 1'b0;
    ADDRESS = 32'h0000_0000;
    @(negedge CLOCK);
    check("t1_busy_detect", BUSYWAIT, 1'b1);
    check("t1_mr_detect", MEM_READ, 1'b0);
    @(negedge CLOCK);
    check("t1_mr", MEM_READ, 1'b1);
    check("t1_ma", MEM_ADDRESS, 28'h0);
    n = 1;
    while (MEM_READ && n < 100) begin
      @(negedge CLOCK);
      if (MEM_READ) n++;
    end
    check("t1_mr_cycles", n, 6);
    check("t1_update_busy", BUSYWAIT, 1'b1);
    @(negedge CLOCK);
    check("t1_hit_busy", BUSYWAIT, 1'b0);
    check("t1_hit_data", READDATA, 32'h8F108093);
    $display("cold miss: memcyc=%0d data=%h", n, READDATA);

    // 2. Same-line hit, no stall
    @(posedge CLOCK); #1;
    ADDRESS = 32'h0000_000C;
    @(negedge CLOCK);
    check("t2_busy", BUSYWAIT, 1'b0);
    check("t2_data", READDATA, 32'h0000F613);
    check("t2_mr", MEM_READ, 1'b0);
    $display("same-line hit: data=%h", READDATA);

    // 3. Conflict miss evicts line 0, then 0x0 misses again
    mem_lat = 2;
    fetch("t3_conf", 32'h0000_0080, 1'b1, 1'b0);
    fetch("t3_refetch0", 32'h0000_0000, 1'b1, 1'b0);
    fetch("t3_hit0", 32'h0000_0004, 1'b0, 1'b0);

    // 4. Reset during the 3rd MEM_READ cycle
    mem_lat = 5;
    @(posedge CLOCK); #1;
    ADDRESS = 32'h0000_0020;
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    @(negedge CLOCK);
    check("t4_mr_before", MEM_READ, 1'b1);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    READ  = 1'b0;
    @(negedge CLOCK);
    check("t4_mr_after", MEM_READ, 1'b0);
    check("t4_ma_after", MEM_ADDRESS, 28'h0);
    check("t4_busy_after", BUSYWAIT, 1'b0);
    $display("reset mid-fill: mem_read=%b", MEM_READ);
    fetch("t4_refetch", 32'h0000_0020, 1'b1, 1'b0);
    fetch("t4_line0_cleared", 32'h0000_0000, 1'b1, 1'b0);

    // 5. Idle, then address stability during a fill
    @(posedge CLOCK); #1;
    READ = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      if (BUSYWAIT || MEM_READ) idle_bad++;
    end
    check("t5_idle", idle_bad, 0);
    $display("idle: active cycles=%0d", idle_bad);
    mem_lat = 3;
    fetch("t5_toggle", 32'h0000_0044, 1'b1, 1'b1);

    // 6. Fill all eight sets, then reread with no stalls
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_lat = i % 4;
      fetch($sformatf("t6_fill%0d", i), 32'h0000_1000 + 32'(i * 16), 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      fetch($sformatf("t6_hit%0d", i), 32'h0000_1000 + 32'(i * 16) + 32'(4 * (i % 4)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
